rtc_write_sequencer: RTL and testbench

- Downstream of the RTC control state machine; consumes its enable_escribir and reset_lg, and produces the listo_guardar it waits on.
- On enable, snapshots N_REGS BCD bytes (time, date and timer values from the user-edit path).
- Writes them one by one to the RTC over a multiplexed address/data bus (cs_n, rd_n, wr_n, a_d, ad_out) with programmable phase timing.
- Flags completion with a sticky listo_guardar.

---
 rtl/rtc_write_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_rtc_write_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_write_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rtc_write_sequencer
//
// Writes a snapshot of N_REGS BCD bytes to an RTC over a multiplexed
// address/data bus. Each register takes four bus phases (ADDR, ADDR_GAP, DATA,
// DATA_GAP) of T_PHASE clocks each. When the last register is written the
// sticky listo_guardar flag is raised for the RTC control FSM.
//
// Handshake: enable_escribir is a level request. A sequence starts on an edge
// where enable_escribir=1 and listo_guardar=0; dropping enable_escribir in any
// busy state aborts the sequence on the next edge. listo_guardar stays set
// until reset_lg (or reset) clears it, and no new sequence starts while it is
// set.
//
// Ports:
//   clk             system clock
//   reset           synchronous, active-high reset
//   enable_escribir level write request from the RTC control FSM
//   reset_lg        clears listo_guardar
//   data_in         N_REGS BCD bytes, byte i goes to ADDR_TABLE byte i
//   listo_guardar   sticky completion flag
//   busy            high while a sequence is in progress
//   cs_n            RTC chip select, active low
//   rd_n            RTC read strobe, always 1
//   wr_n            RTC write strobe, active low
//   a_d             0 = address phase, 1 = data phase
//   ad_out          bus value
//   ad_oe           tri-state enable for ad_out
// -----------------------------------------------------------------------------
module rtc_write_sequencer #(
    parameter int                  N_REGS     = 9,
    parameter int                  T_PHASE    = 4,
    parameter logic [8*N_REGS-1:0] ADDR_TABLE = 72'h43_42_41_26_25_24_23_22_21
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable_escribir,
    input  logic                reset_lg,
    input  logic [8*N_REGS-1:0] data_in,
    output logic                listo_guardar,
    output logic                busy,
    output logic                cs_n,
    output logic                rd_n,
    output logic                wr_n,
    output logic                a_d,
    output logic [7:0]          ad_out,
    output logic                ad_oe
);

    localparam int IW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam int PW = $clog2(T_PHASE) + 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_GAP = 3'd2,
        DATA     = 3'd3,
        DATA_GAP = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t              state, state_n;
    logic [IW-1:0]       idx, idx_n;
    logic [PW-1:0]       cnt, cnt_n;
    logic [8*N_REGS-1:0] shadow, shadow_n;
    logic                listo_n;
    logic                start;
    logic                phase_end;

    logic                busy_n, cs_n_n, wr_n_n, a_d_n, ad_oe_n;
    logic [7:0]          ad_out_n;

    // State, counters, shadow and all outputs are registered together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            cnt           <= '0;
            shadow        <= '0;
            listo_guardar <= 1'b0;
            busy          <= 1'b0;
            cs_n          <= 1'b1;
            rd_n          <= 1'b1;
            wr_n          <= 1'b1;
            a_d           <= 1'b1;
            ad_out        <= 8'h00;
            ad_oe         <= 1'b0;
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            cnt           <= cnt_n;
            shadow        <= shadow_n;
            listo_guardar <= listo_n;
            busy          <= busy_n;
            cs_n          <= cs_n_n;
            rd_n          <= 1'b1;
            wr_n          <= wr_n_n;
            a_d           <= a_d_n;
            ad_out        <= ad_out_n;
            ad_oe         <= ad_oe_n;
        end
    end

    // Next state, counters and sticky flag.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        cnt_n     = cnt;
        shadow_n  = shadow;
        listo_n   = listo_guardar;
        start     = 1'b0;
        phase_end = (cnt == PW'(T_PHASE - 1));

        case (state)
            IDLE: begin
                start = enable_escribir && !listo_guardar;
            end
            ADDR, ADDR_GAP, DATA, DATA_GAP: begin
                if (!enable_escribir) begin
                    // Abort: the partial write is abandoned.
                    state_n = IDLE;
                    idx_n   = '0;
                    cnt_n   = '0;
                end else if (phase_end) begin
                    cnt_n = '0;
                    case (state)
                        ADDR:     state_n = ADDR_GAP;
                        ADDR_GAP: state_n = DATA;
                        DATA:     state_n = DATA_GAP;
                        default: begin
                            if (idx == IW'(N_REGS - 1)) begin
                                state_n = DONE;
                            end else begin
                                idx_n   = idx + IW'(1);
                                state_n = ADDR;
                            end
                        end
                    endcase
                end else begin
                    cnt_n = cnt + PW'(1);
                end
            end
            DONE: begin
                // A cleared flag with enable still high starts a fresh save.
                if (!enable_escribir) begin
                    state_n = IDLE;
                    idx_n   = '0;
                end else begin
                    start = !listo_guardar;
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
                cnt_n   = '0;
            end
        endcase

        if (start) begin
            state_n  = ADDR;
            idx_n    = '0;
            cnt_n    = '0;
            shadow_n = data_in;
        end

        // Entry into DONE beats a simultaneous reset_lg.
        if (state != DONE && state_n == DONE) begin
            listo_n = 1'b1;
        end else if (reset_lg) begin
            listo_n = 1'b0;
        end
    end

    // Bus values are derived from the next state so they change on the same
    // edge as the state; gap phases hold the previous bus value.
    always_comb begin
        busy_n   = 1'b0;
        cs_n_n   = 1'b1;
        wr_n_n   = 1'b1;
        a_d_n    = 1'b1;
        ad_out_n = 8'h00;
        ad_oe_n  = 1'b0;

        case (state_n)
            ADDR: begin
                busy_n   = 1'b1;
                cs_n_n   = 1'b0;
                wr_n_n   = 1'b0;
                a_d_n    = 1'b0;
                ad_oe_n  = 1'b1;
                ad_out_n = ADDR_TABLE[8*int'(idx_n) +: 8];
            end
            ADDR_GAP: begin
                busy_n   = 1'b1;
                a_d_n    = 1'b0;
                ad_oe_n  = 1'b1;
                ad_out_n = ad_out;
            end
            DATA: begin
                busy_n   = 1'b1;
                cs_n_n   = 1'b0;
                wr_n_n   = 1'b0;
                a_d_n    = 1'b1;
                ad_oe_n  = 1'b1;
                ad_out_n = shadow_n[8*int'(idx_n) +: 8];
            end
            DATA_GAP: begin
                busy_n   = 1'b1;
                a_d_n    = 1'b1;
                ad_oe_n  = 1'b1;
                ad_out_n = ad_out;
            end
            default: begin
                busy_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rtc_write_sequencer.sv
`timescale 1ns/1ps
module tb_rtc_write_sequencer;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        enable_escribir;
    logic        reset_lg;
    logic [71:0] data_in;
    logic        listo_guardar, busy, cs_n, rd_n, wr_n, a_d, ad_oe;
    logic [7:0]  ad_out;

    logic        enable2, reset_lg2;
    logic [15:0] data_in2;
    logic        listo2, busy2, cs_n2, rd_n2, wr_n2, a_d2, ad_oe2;
    logic [7:0]  ad_out2;

    rtc_write_sequencer dut (
        .clk(clk), .reset(reset), .enable_escribir(enable_escribir),
        .reset_lg(reset_lg), .data_in(data_in), .listo_guardar(listo_guardar),
        .busy(busy), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d),
        .ad_out(ad_out), .ad_oe(ad_oe)
    );

    rtc_write_sequencer #(.N_REGS(2), .T_PHASE(1), .ADDR_TABLE(16'h22_21)) dut2 (
        .clk(clk), .reset(reset), .enable_escribir(enable2),
        .reset_lg(reset_lg2), .data_in(data_in2), .listo_guardar(listo2),
        .busy(busy2), .cs_n(cs_n2), .rd_n(rd_n2), .wr_n(wr_n2), .a_d(a_d2),
        .ad_out(ad_out2), .ad_oe(ad_oe2)
    );

    int checks = 0;
    int failures = 0;
    int strobe_cnt = 0;

    // scoreboard: {a_d, ad_out} expected at the start of every strobe
    logic [8:0]  exp_q[$];
    logic [71:0] addr_tab = 72'h43_42_41_26_25_24_23_22_21;
    logic        width_chk = 1'b1;

    logic        prev_cs_n = 1'b1, prev_wr_n = 1'b1, prev_a_d = 1'b1;
    logic [7:0]  prev_ad = 8'h00;
    int          wr_len = 0;
    logic [8:0]  exp_item;

    always @(negedge clk) begin
        if (cs_n === 1'b0 && prev_cs_n === 1'b1) begin
            strobe_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe got a_d=%0b ad_out=%02h, queue empty", a_d, ad_out);
            end else begin
                exp_item = exp_q.pop_front();
                if ({a_d, ad_out} !== exp_item) begin
                    failures++;
                    $display("FAIL strobe_value got a_d=%0b ad_out=%02h expected a_d=%0b ad_out=%02h",
                             a_d, ad_out, exp_item[8], exp_item[7:0]);
                end
            end
        end
        if (cs_n === 1'b0 && prev_cs_n === 1'b0) begin
            checks++;
            if (a_d !== prev_a_d || ad_out !== prev_ad) begin
                failures++;
                $display("FAIL bus_stable got a_d=%0b ad_out=%02h expected a_d=%0b ad_out=%02h",
                         a_d, ad_out, prev_a_d, prev_ad);
            end
        end
        checks++;
        if (wr_n !== cs_n) begin
            failures++;
            $display("FAIL wr_cs_align got wr_n=%0b expected %0b", wr_n, cs_n);
        end
        if (wr_n === 1'b0) begin
            wr_len++;
        end else if (prev_wr_n === 1'b0) begin
            if (width_chk) begin
                checks++;
                if (wr_len != 4) begin
                    failures++;
                    $display("FAIL wr_width got %0d expected 4", wr_len);
                end
            end
            wr_len = 0;
        end
        prev_cs_n = cs_n;
        prev_wr_n = wr_n;
        prev_a_d  = a_d;
        prev_ad   = ad_out;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pairs(input logic [71:0] d, input int n_items);
        for (int k = 0; k < n_items; k++) begin
            if (k % 2 == 0) exp_q.push_back({1'b0, addr_tab[(k/2)*8 +: 8]});
            else            exp_q.push_back({1'b1, d[(k/2)*8 +: 8]});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable_escribir = 1'b0; reset_lg = 1'b0; data_in = '0;
        enable2 = 1'b0; reset_lg2 = 1'b0; data_in2 = '0;
        tick(); tick();
        checks++;
        if ({listo_guardar, busy, cs_n, rd_n, wr_n, a_d, ad_out, ad_oe} !== {6'b001111, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL reset_values got listo=%0b busy=%0b cs_n=%0b rd_n=%0b wr_n=%0b a_d=%0b ad=%02h oe=%0b expected 0 0 1 1 1 1 00 0",
                     listo_guardar, busy, cs_n, rd_n, wr_n, a_d, ad_out, ad_oe);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_full_sequence();
        data_in = 72'h01_10_05_99_12_31_23_59_30;
        push_pairs(data_in, 18);
        enable_escribir = 1'b1;
        tick();
        checks++;
        if (cs_n !== 1'b0 || busy !== 1'b1 || ad_oe !== 1'b1) begin
            failures++;
            $display("FAIL start_edge got cs_n=%0b busy=%0b oe=%0b expected 0 1 1", cs_n, busy, ad_oe);
        end
        for (int c = 1; c <= 144; c++) begin
            tick();
            if (c == 143) begin
                checks++;
                if (listo_guardar !== 1'b0 || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL pre_done got listo=%0b busy=%0b expected 0 1", listo_guardar, busy);
                end
            end
        end
        checks++;
        if (listo_guardar !== 1'b1 || busy !== 1'b0 || ad_oe !== 1'b0 || cs_n !== 1'b1 || ad_out !== 8'h00) begin
            failures++;
            $display("FAIL done_edge got listo=%0b busy=%0b oe=%0b cs_n=%0b ad=%02h expected 1 0 0 1 00",
                     listo_guardar, busy, ad_oe, cs_n, ad_out);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL full_seq_drain got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_done_hold();
        int s0;
        s0 = strobe_cnt;
        repeat (20) tick();
        checks++;
        if (strobe_cnt != s0 || listo_guardar !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_hold got strobes=%0d listo=%0b busy=%0b expected %0d 1 0",
                     strobe_cnt, listo_guardar, busy, s0);
        end
    endtask

    task automatic test_clear_restart_snapshot();
        data_in = 72'h88_77_66_55_44_33_22_11_00;
        push_pairs(data_in, 18);
        reset_lg = 1'b1;
        tick();
        reset_lg = 1'b0;
        checks++;
        if (listo_guardar !== 1'b0 || cs_n !== 1'b1) begin
            failures++;
            $display("FAIL lg_clear got listo=%0b cs_n=%0b expected 0 1", listo_guardar, cs_n);
        end
        tick();
        checks++;
        if (busy !== 1'b1 || cs_n !== 1'b0 || ad_out !== 8'h21) begin
            failures++;
            $display("FAIL restart_after_clear got busy=%0b cs_n=%0b ad=%02h expected 1 0 21", busy, cs_n, ad_out);
        end
        for (int c = 1; c <= 144; c++) begin
            if (c == 10) data_in = {9{8'hFF}};
            if (c == 144) reset_lg = 1'b1;
            tick();
        end
        reset_lg = 1'b0;
        checks++;
        if (listo_guardar !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL set_wins got listo=%0b busy=%0b expected 1 0", listo_guardar, busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL snapshot_drain got %0d pending expected 0", exp_q.size());
        end
        enable_escribir = 1'b0;
        tick();
        checks++;
        if (listo_guardar !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL sticky_idle got listo=%0b busy=%0b expected 1 0", listo_guardar, busy);
        end
    endtask

    task automatic test_abort();
        reset_lg = 1'b1;
        tick();
        reset_lg = 1'b0;
        data_in = 72'h09_08_07_06_05_04_03_02_01;
        push_pairs(data_in, 8);
        enable_escribir = 1'b1;
        tick();
        repeat (57) tick();
        width_chk = 1'b0;
        enable_escribir = 1'b0;
        tick();
        checks++;
        if (cs_n !== 1'b1 || wr_n !== 1'b1 || busy !== 1'b0 || listo_guardar !== 1'b0 || ad_oe !== 1'b0) begin
            failures++;
            $display("FAIL abort got cs_n=%0b wr_n=%0b busy=%0b listo=%0b oe=%0b expected 1 1 0 0 0",
                     cs_n, wr_n, busy, listo_guardar, ad_oe);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL abort_drain got %0d pending expected 0", exp_q.size());
        end
        tick();
        width_chk = 1'b1;
    endtask

    task automatic test_reset_mid();
        int s0;
        data_in = 72'h19_18_17_16_15_14_13_12_11;
        push_pairs(data_in, 9);
        enable_escribir = 1'b1;
        tick();
        checks++;
        if (ad_out !== 8'h21 || a_d !== 1'b0 || cs_n !== 1'b0) begin
            failures++;
            $display("FAIL restart_addr got ad=%02h a_d=%0b cs_n=%0b expected 21 0 0", ad_out, a_d, cs_n);
        end
        repeat (64) tick();
        width_chk = 1'b0;
        reset = 1'b1;
        enable_escribir = 1'b0;
        tick();
        checks++;
        if ({listo_guardar, busy, cs_n, rd_n, wr_n, a_d, ad_out, ad_oe} !== {6'b001111, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid got listo=%0b busy=%0b cs_n=%0b rd_n=%0b wr_n=%0b a_d=%0b ad=%02h oe=%0b expected 0 0 1 1 1 1 00 0",
                     listo_guardar, busy, cs_n, rd_n, wr_n, a_d, ad_out, ad_oe);
        end
        reset = 1'b0;
        s0 = strobe_cnt;
        repeat (20) tick();
        checks++;
        if (strobe_cnt != s0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL reset_mid_quiet got strobes=%0d pending=%0d expected %0d 0", strobe_cnt, exp_q.size(), s0);
        end
        width_chk = 1'b1;
    endtask

    task automatic test_short_phase();
        logic [15:0] addr2;
        logic        e_cs, e_ad;
        logic [7:0]  e_out;
        int          p, r;
        addr2 = 16'h22_21;
        data_in2 = 16'h67_45;
        enable2 = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            p = k % 4;
            r = k / 4;
            e_cs  = (p == 0 || p == 2) ? 1'b0 : 1'b1;
            e_ad  = (p >= 2);
            e_out = (p < 2) ? addr2[r*8 +: 8] : data_in2[r*8 +: 8];
            checks++;
            if (cs_n2 !== e_cs || wr_n2 !== e_cs || a_d2 !== e_ad || ad_out2 !== e_out || listo2 !== 1'b0) begin
                failures++;
                $display("FAIL short_phase_k%0d got cs=%0b wr=%0b a_d=%0b ad=%02h listo=%0b expected %0b %0b %0b %02h 0",
                         k, cs_n2, wr_n2, a_d2, ad_out2, listo2, e_cs, e_cs, e_ad, e_out);
            end
            tick();
        end
        checks++;
        if (listo2 !== 1'b1 || busy2 !== 1'b0 || cs_n2 !== 1'b1) begin
            failures++;
            $display("FAIL short_done got listo=%0b busy=%0b cs_n=%0b expected 1 0 1", listo2, busy2, cs_n2);
        end
        enable2 = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_full_sequence();
        test_done_hold();
        test_clear_restart_snapshot();
        test_abort();
        test_reset_mid();
        test_short_phase();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
